// File: rtl/hex_display_arbiter.sv
// Two-requester arbiter that shares one hex-to-7-segment decoder across six
// registered active-low digit outputs. A two-stage pipeline registers the grant, then writes the digit.

module hex_display_arbiter (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic [4:0] VAL_A,
  input  logic [2:0] IDX_A,
  input  logic       REQ_B,
  input  logic [4:0] VAL_B,
  input  logic [2:0] IDX_B,
  input  logic       LT,
  output logic       ACK_A,
  output logic       ACK_B,
  output logic       ERR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // Handshake: a requester raises REQ with VAL/IDX stable and holds them until
  // its one-cycle ACK. A grant is final, so the write still lands if REQ then drops.

  logic       ptr_b;
  logic       s1_valid;
  logic       s1_sel_b;
  logic [4:0] s1_val;
  logic [2:0] s1_idx;
  logic [6:0] hex_q [6];

  logic       elig_a;
  logic       elig_b;
  logic       gnt_any;
  logic       gnt_b;
  logic [4:0] win_val;
  logic [2:0] win_idx;
  logic [6:0] seg;
  logic       idx_bad;

  function automatic logic [6:0] seg_decode(input logic [4:0] v);
    logic [6:0] s;
    s = 7'h7F;
    if (!v[4]) begin
      case (v[3:0])
        4'h0: s = 7'h40;
        4'h1: s = 7'h79;
        4'h2: s = 7'h24;
        4'h3: s = 7'h30;
        4'h4: s = 7'h19;
        4'h5: s = 7'h12;
        4'h6: s = 7'h02;
        4'h7: s = 7'h78;
        4'h8: s = 7'h00;
        4'h9: s = 7'h10;
        4'hA: s = 7'h08;
        4'hB: s = 7'h03;
        4'hC: s = 7'h46;
        4'hD: s = 7'h21;
        4'hE: s = 7'h06;
        default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // A requester granted on the previous edge sits out one edge, which is what
  // lets two held requesters alternate at one write per cycle.
  always_comb begin
    elig_a  = REQ_A && !(s1_valid && !s1_sel_b);
    elig_b  = REQ_B && !(s1_valid && s1_sel_b);
    gnt_any = elig_a || elig_b;
    gnt_b   = elig_b && (!elig_a || ptr_b);
    win_val = gnt_b ? VAL_B : VAL_A;
    win_idx = gnt_b ? IDX_B : IDX_A;
    seg     = seg_decode(s1_val);
    idx_bad = (s1_idx[2:1] == 2'b11);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ptr_b    <= 1'b0;
      s1_valid <= 1'b0;
      s1_sel_b <= 1'b0;
      s1_val   <= 5'h00;
      s1_idx   <= 3'h0;
      ACK_A    <= 1'b0;
      ACK_B    <= 1'b0;
      ERR      <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
    end else begin
      s1_valid <= gnt_any;
      s1_sel_b <= gnt_b;
      if (gnt_any) begin
        s1_val <= win_val;
        s1_idx <= win_idx;
        ptr_b  <= !gnt_b;
      end
      ACK_A <= s1_valid && !s1_sel_b;
      ACK_B <= s1_valid && s1_sel_b;
      ERR   <= s1_valid && idx_bad;
      if (s1_valid && !idx_bad) hex_q[s1_idx] <= seg;
    end
  end

  // Lamp test overrides the stored digits without touching them.
  assign HEX0 = LT ? 7'h00 : hex_q[0];
  assign HEX1 = LT ? 7'h00 : hex_q[1];
  assign HEX2 = LT ? 7'h00 : hex_q[2];
  assign HEX3 = LT ? 7'h00 : hex_q[3];
  assign HEX4 = LT ? 7'h00 : hex_q[4];
  assign HEX5 = LT ? 7'h00 : hex_q[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: tests push expected ACKs, a
// negedge monitor pops and checks requester, ERR and the written digit.

module tb_hex_display_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, lt;
  logic [4:0] val_a, val_b;
  logic [2:0] idx_a, idx_b;
  logic       ack_a, ack_b, err;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int checks = 0;
  int errors = 0;

  // {requester_b, err, idx[2:0], seg[6:0]}
  logic [11:0] exp_q[$];
  logic [6:0]  exp_hex [6];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_arbiter dut (
    .CLOCK_50(clk), .RESET(reset),
    .REQ_A(req_a), .VAL_A(val_a), .IDX_A(idx_a),
    .REQ_B(req_b), .VAL_B(val_b), .IDX_B(idx_b),
    .LT(lt), .ACK_A(ack_a), .ACK_B(ack_b), .ERR(err),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_of(input int i);
    case (i)
      0: return hex0;
      1: return hex1;
      2: return hex2;
      3: return hex3;
      4: return hex4;
      default: return hex5;
    endcase
  endfunction

  task automatic push_exp(input logic id_b, input logic e, input logic [2:0] idx, input logic [6:0] s);
    exp_q.push_back({id_b, e, idx, s});
  endtask

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 6; i++) check7($sformatf("%s_hex%0d", name, i), hex_of(i), exp_hex[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
  endtask

  // Raise REQ, hold until this requester's ACK is seen, then drop it.
  task automatic do_req(input logic id_b, input logic [4:0] val, input logic [2:0] idx);
    logic got;
    if (id_b) begin req_b = 1'b1; val_b = val; idx_b = idx; end
    else      begin req_a = 1'b1; val_a = val; idx_a = idx; end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id_b ? ack_b : ack_a;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ACK within 20 cycles", id_b);
    end
    if (id_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d ACKs still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every ACK must match the head of the queue.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack_a=%b ack_b=%b err=%b, expected no ACK", ack_a, ack_b, err);
        end else begin
          e = exp_q.pop_front();
          if ((ack_a && ack_b) || ack_b !== e[11] || err !== e[10]) begin
            errors++;
            $display("FAIL ack_id_err: ack_a=%b ack_b=%b err=%b, expected requester %0d err=%b",
                     ack_a, ack_b, err, e[11], e[10]);
          end
          if (!e[10] && !lt) begin
            checks++;
            if (hex_of(int'(e[9:7])) !== e[6:0]) begin
              errors++;
              $display("FAIL ack_digit: hex%0d=%h at ACK, expected %h", e[9:7], hex_of(int'(e[9:7])), e[6:0]);
            end
          end
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_ack: err=1 with no ACK");
      end
    end
  end

  initial begin
    reset = 1'b1; lt = 1'b0;
    req_a = 1'b0; val_a = 5'h00; idx_a = 3'h0;
    req_b = 1'b0; val_b = 5'h00; idx_b = 3'h0;
    for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
    repeat (2) @(negedge clk);
    check_all("reset");
    check7("reset_acks", {4'h0, ack_a, ack_b, err}, 7'h00);
    reset = 1'b0;
    @(negedge clk);

    // Single write after reset: 3 to HEX2
    push_exp(1'b0, 1'b0, 3'd2, 7'h30);
    do_req(1'b0, 5'h03, 3'd2);
    exp_hex[2] = 7'h30;
    check_all("single");
    drain("single");

    // Simultaneous request, pointer at A: A (7) then B (F) to HEX0
    do_reset();
    push_exp(1'b0, 1'b0, 3'd0, 7'h78);
    push_exp(1'b1, 1'b0, 3'd0, 7'h0E);
    fork
      do_req(1'b0, 5'h07, 3'd0);
      do_req(1'b1, 5'h0F, 3'd0);
    join
    exp_hex[0] = 7'h0E;
    check7("both_hex0", hex0, 7'h0E);
    drain("both");

    // Both held: A,B,A,B alternate; B's last grant completes after REQ drops
    push_exp(1'b0, 1'b0, 3'd3, 7'h79);
    push_exp(1'b1, 1'b0, 3'd4, 7'h24);
    push_exp(1'b0, 1'b0, 3'd3, 7'h79);
    push_exp(1'b1, 1'b0, 3'd4, 7'h24);
    req_a = 1'b1; val_a = 5'h01; idx_a = 3'd3;
    req_b = 1'b1; val_b = 5'h02; idx_b = 3'd4;
    repeat (4) @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    drain("alternate");
    exp_hex[3] = 7'h79; exp_hex[4] = 7'h24;
    check_all("alternate");

    // Out-of-range indices: ACK plus ERR, no digit change
    push_exp(1'b1, 1'b1, 3'd6, 7'h00);
    do_req(1'b1, 5'h01, 3'd6);
    push_exp(1'b0, 1'b1, 3'd7, 7'h00);
    do_req(1'b0, 5'h0A, 3'd7);
    drain("err");
    check_all("err");

    // Full decode table across all six digits
    for (int i = 0; i < 16; i++) begin
      push_exp(1'b0, 1'b0, 3'(i % 6), seg_tab[i]);
      do_req(1'b0, 5'(i), 3'(i % 6));
      exp_hex[i % 6] = seg_tab[i];
    end
    drain("decode");
    check_all("decode");

    // Same digit back to back, then blank overrides the nibble
    push_exp(1'b0, 1'b0, 3'd5, 7'h00);
    do_req(1'b0, 5'h08, 3'd5);
    check7("hex5_eight", hex5, 7'h00);
    push_exp(1'b0, 1'b0, 3'd5, 7'h7F);
    do_req(1'b0, 5'h18, 3'd5);
    check7("hex5_blank", hex5, 7'h7F);
    push_exp(1'b1, 1'b0, 3'd0, 7'h7F);
    do_req(1'b1, 5'h13, 3'd0);
    exp_hex[5] = 7'h7F; exp_hex[0] = 7'h7F;
    drain("blank");
    check_all("blank");

    // Lamp test: all lit, a write during LT still lands
    push_exp(1'b0, 1'b0, 3'd1, 7'h79);
    do_req(1'b0, 5'h01, 3'd1);
    exp_hex[1] = 7'h79;
    #2 lt = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) check7($sformatf("lamp_hex%0d", i), hex_of(i), 7'h00);
    @(negedge clk);
    push_exp(1'b0, 1'b0, 3'd2, 7'h24);
    do_req(1'b0, 5'h02, 3'd2);
    exp_hex[2] = 7'h24;
    drain("lamp");
    #2 lt = 1'b0;
    #1;
    check_all("lamp_off");

    // Reset one cycle after a grant: write and ACK discarded, pointer back to A
    @(negedge clk);
    req_a = 1'b1; val_a = 5'h00; idx_a = 3'd0;
    @(negedge clk);
    req_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
    repeat (3) @(negedge clk);
    check_all("midreset");
    check7("midreset_acks", {4'h0, ack_a, ack_b, err}, 7'h00);
    push_exp(1'b0, 1'b0, 3'd0, 7'h46);
    push_exp(1'b1, 1'b0, 3'd0, 7'h21);
    fork
      do_req(1'b0, 5'h0C, 3'd0);
      do_req(1'b1, 5'h0D, 3'd0);
    join
    exp_hex[0] = 7'h21;
    drain("ptr_reset");
    check_all("ptr_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
